// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serial transmitter for configuration bursts. Each accepted byte is sent as
// one start bit (0), DATA_BIT_CNT_MAX+1 data bits LSB first, and one stop
// bit (1), every bit lasting BIT_PERIOD clocks. Bytes are numbered with a
// descending index that wraps from 0 back to BURST_LEN_MAX, so one burst
// is BURST_LEN_MAX+1 bytes and ends with the byte carrying index 0.
//
// State table
//   state | meaning
//   IDLE  | line high, data_ready high, waiting for data_valid
//   START | driving the start bit (low) for one bit period
//   DATA  | shifting data bits out LSB first, one bit period each
//   STOP  | driving the stop bit (high) for one bit period
//
// Ports
//   clk        : single clock, rising-edge logic
//   rst        : synchronous, active-high reset
//   data_in    : byte to transmit, captured on accept
//   data_valid : data_in holds a byte to send
//   data_ready : block can accept a byte this cycle (IDLE and not in reset)
//   uart_data  : registered serial line, idle high
//   busy       : a frame is in progress
//   byte_idx   : index of the byte last accepted
//   burst_done : one-cycle pulse when the byte with index 0 finishes
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int BIT_PERIOD       = 52,
    parameter int DATA_BIT_CNT_MAX = 7,
    parameter int BURST_LEN_MAX    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       uart_data,
    output logic       busy,
    output logic [2:0] byte_idx,
    output logic       burst_done
);

    // Bit-period counter only has to hold BIT_PERIOD-1.
    localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BIT_PERIOD - 1);

    localparam int BIT_W = (DATA_BIT_CNT_MAX > 0) ? $clog2(DATA_BIT_CNT_MAX + 1) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BIT_CNT_MAX);

    localparam logic [2:0] IDX_WRAP = 3'(BURST_LEN_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_period_cnt;
    logic [BIT_W-1:0] data_bit_cnt;
    logic [7:0]       shift_reg;
    logic             accept;
    logic             period_end;

    // data_ready is gated by rst directly so a byte offered during reset is
    // never acknowledged, and so it rises in the very first cycle after rst.
    assign data_ready = (state == IDLE) && !rst;
    assign accept     = data_valid && data_ready;
    assign period_end = (bit_period_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            uart_data      <= 1'b1;
            busy           <= 1'b0;
            burst_done     <= 1'b0;
            byte_idx       <= 3'd0;
            bit_period_cnt <= CNT_RELOAD;
            data_bit_cnt   <= '0;
            shift_reg      <= 8'h00;
        end else begin
            burst_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg      <= data_in;
                        state          <= START;
                        uart_data      <= 1'b0;
                        busy           <= 1'b1;
                        bit_period_cnt <= CNT_RELOAD;
                        byte_idx       <= (byte_idx != 3'd0) ? byte_idx - 3'd1 : IDX_WRAP;
                    end
                end

                START: begin
                    if (period_end) begin
                        state          <= DATA;
                        uart_data      <= shift_reg[0];
                        shift_reg      <= {1'b0, shift_reg[7:1]};
                        data_bit_cnt   <= '0;
                        bit_period_cnt <= CNT_RELOAD;
                    end else begin
                        bit_period_cnt <= bit_period_cnt - 1'b1;
                    end
                end

                DATA: begin
                    if (period_end) begin
                        bit_period_cnt <= CNT_RELOAD;
                        if (data_bit_cnt == BIT_LAST) begin
                            state     <= STOP;
                            uart_data <= 1'b1;
                        end else begin
                            uart_data    <= shift_reg[0];
                            shift_reg    <= {1'b0, shift_reg[7:1]};
                            data_bit_cnt <= data_bit_cnt + 1'b1;
                        end
                    end else begin
                        bit_period_cnt <= bit_period_cnt - 1'b1;
                    end
                end

                STOP: begin
                    if (period_end) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        bit_period_cnt <= CNT_RELOAD;
                        // Last byte of a burst: pulse lines up with data_ready rising.
                        burst_done     <= (byte_idx == 3'd0);
                    end else begin
                        bit_period_cnt <= bit_period_cnt - 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    uart_data <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] din_a, din_b;
    logic       dv_a, dv_b;
    logic       dr_a, dr_b;
    logic       line_a, line_b;
    logic       busy_a, busy_b;
    logic [2:0] idx_a, idx_b;
    logic       bd_a, bd_b;

    uart_tx dut_a (
        .clk(clk), .rst(rst), .data_in(din_a), .data_valid(dv_a),
        .data_ready(dr_a), .uart_data(line_a), .busy(busy_a),
        .byte_idx(idx_a), .burst_done(bd_a)
    );

    uart_tx #(.BIT_PERIOD(2)) dut_b (
        .clk(clk), .rst(rst), .data_in(din_b), .data_valid(dv_b),
        .data_ready(dr_b), .uart_data(line_b), .busy(busy_b),
        .byte_idx(idx_b), .burst_done(bd_b)
    );

    int checks   = 0;
    int failures = 0;

    // Per-frame capture for dut_a: index n is the value seen after the
    // (n-1)th rising edge counted from the accept edge.
    logic       ln  [1:521];
    logic       rdy [1:521];
    logic       bsy [1:521];
    int         bd_cnt;
    logic       bd_end;
    logic [2:0] idx_first;
    logic [7:0] rx_mem [0:7];
    logic       lnb [1:21];
    logic       rdyb [1:21];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: single byte, 1: data_valid held high, 2: data_valid toggled with 0xFF while busy
    task automatic run_frame_a(input logic [7:0] b, input int mode);
        din_a  = b;
        dv_a   = 1'b1;
        bd_cnt = 0;
        for (int n = 1; n <= 521; n++) begin
            tick();
            ln[n]  = line_a;
            rdy[n] = dr_a;
            bsy[n] = busy_a;
            if (n <= 520 && bd_a === 1'b1) bd_cnt++;
            if (n == 1) begin
                idx_first = idx_a;
                if (mode == 0) dv_a = 1'b0;
                if (mode == 2) din_a = 8'hFF;
            end
            if (mode == 2) dv_a = (n < 500) ? ((n % 2) == 1) : 1'b0;
        end
        bd_end = bd_a;
    endtask

    task automatic check_frame_a(input logic [7:0] b, input string tag);
        int   errs;
        logic exp;
        for (int s = 0; s < 10; s++) begin
            errs = 0;
            exp  = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
            for (int c = 1; c <= 52; c++)
                if (ln[52*s + c] !== exp) errs++;
            check($sformatf("%s_slot%0d_bad_cycles", tag, s), errs, 0);
        end
        errs = 0;
        for (int n = 1; n <= 520; n++)
            if (bsy[n] !== 1'b1 || rdy[n] !== 1'b0) errs++;
        check($sformatf("%s_busy_ready_in_frame", tag), errs, 0);
        check($sformatf("%s_ready_at_521", tag), rdy[521], 1);
        check($sformatf("%s_busy_at_521", tag), bsy[521], 0);
    endtask

    function automatic logic [7:0] decode_a();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = ln[52*(k+1) + 26];
        return r;
    endfunction

    initial begin
        rst   = 1'b1;
        dv_a  = 1'b0;
        din_a = 8'h00;
        dv_b  = 1'b0;
        din_b = 8'h00;
        for (int i = 0; i < 8; i++) rx_mem[i] = 8'h00;

        // reset state
        repeat (3) tick();
        check("rst_line", line_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_ready", dr_a, 0);
        check("rst_burst_done", bd_a, 0);
        check("rst_byte_idx", idx_a, 0);

        // byte offered while rst is high is dropped
        dv_a  = 1'b1;
        din_a = 8'hC3;
        tick();
        check("rst_accept_ready_low", dr_a, 0);
        rst  = 1'b0;
        dv_a = 1'b0;
        #1;
        check("ready_first_cycle_after_rst", dr_a, 1);
        begin
            int errs = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (line_a !== 1'b1 || busy_a !== 1'b0) errs++;
            end
            check("no_start_after_rst_accept", errs, 0);
        end
        check("idx_after_dropped", idx_a, 0);

        // single byte 0xA5
        run_frame_a(8'hA5, 0);
        check("a5_byte_idx", idx_first, 5);
        check_frame_a(8'hA5, "a5");
        check("a5_no_burst_done", bd_cnt + bd_end, 0);

        // fresh burst of six bytes
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            run_frame_a(8'(k + 1), 1);
            check($sformatf("burst%0d_idx", k), idx_first, 5 - k);
            check_frame_a(8'(k + 1), $sformatf("burst%0d", k));
            rx_mem[idx_first] = decode_a();
            check($sformatf("burst%0d_bd_inside", k), bd_cnt, 0);
            check($sformatf("burst%0d_bd_end", k), bd_end, (k == 5) ? 1 : 0);
        end
        dv_a = 1'b0;
        tick();
        check("burst_done_one_cycle", bd_a, 0);
        check("no_seventh_frame_busy", busy_a, 0);
        check("no_seventh_frame_line", line_a, 1);
        check("loopback_addr0", rx_mem[0], 8'h06);
        check("loopback_addr2", rx_mem[2], 8'h04);
        check("loopback_addr5", rx_mem[5], 8'h01);

        // 0x00 frame with noise on data_valid / data_in
        run_frame_a(8'h00, 2);
        check("noisy_idx_wrap", idx_first, 5);
        check_frame_a(8'h00, "noisy");
        begin
            int errs = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (line_a !== 1'b1 || busy_a !== 1'b0) errs++;
            end
            check("noisy_no_extra_frame", errs, 0);
        end

        // reset in the middle of a 0x5A frame
        din_a = 8'h5A;
        dv_a  = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == 1) dv_a = 1'b0;
        end
        check("midrst_line_c200", line_a, 0);
        rst = 1'b1;
        tick();
        check("midrst_line_c201", line_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_idx", idx_a, 0);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", dr_a, 1);
        begin
            int errs = 0;
            for (int i = 0; i < 60; i++) begin
                tick();
                if (line_a !== 1'b1) errs++;
            end
            check("midrst_no_partial_bits", errs, 0);
        end
        run_frame_a(8'h3C, 0);
        check("post_rst_idx", idx_first, 5);
        check_frame_a(8'h3C, "post_rst");

        // BIT_PERIOD=2 build, byte 0x80
        din_b = 8'h80;
        dv_b  = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            tick();
            lnb[n]  = line_b;
            rdyb[n] = dr_b;
            if (n == 1) dv_b = 1'b0;
        end
        begin
            int errs = 0;
            for (int n = 1; n <= 20; n++) begin
                int   slot;
                logic exp;
                slot = (n - 1) / 2;
                exp  = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : din_b[slot-1];
                if (lnb[n] !== exp) errs++;
            end
            check("bp2_frame_bad_cycles", errs, 0);
        end
        check("bp2_start_c1", lnb[1], 0);
        check("bp2_bit6_c16", lnb[16], 0);
        check("bp2_msb_c17", lnb[17], 1);
        check("bp2_msb_c18", lnb[18], 1);
        check("bp2_ready_c20", rdyb[20], 0);
        check("bp2_ready_c21", rdyb[21], 1);
        check("bp2_idx", idx_b, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
